// File: rtl/rtc_bus_responder.sv
// Real-time clock register block behind a multiplexed, active-low address/data bus.
// Six BCD timekeeping registers (0x21-0x26) advance once every TICKS_PER_SEC clock cycles.
module rtc_bus_responder #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    inout  wire  [7:0] add_data_rtc,
    output logic       segundo_pulso
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;

    logic          prev_a_d;
    logic          prev_cs;
    logic          prev_rd;
    logic          prev_wr;
    logic [7:0]    prev_bus;
    logic [7:0]    bus_hold;
    logic [7:0]    addr;
    logic [7:0]    rbuf;
    logic [7:0]    rd_mux;
    logic          oe;

    logic          load_addr;
    logic          load_rbuf;
    logic          commit_wr;

    logic [PW-1:0] presc;
    logic          tick;

    logic [7:0]    rtc_sec;
    logic [7:0]    rtc_min;
    logic [7:0]    rtc_hour;
    logic [7:0]    rtc_day;
    logic [7:0]    rtc_mon;
    logic [7:0]    rtc_year;
    logic [7:0]    sec_d;
    logic [7:0]    min_d;
    logic [7:0]    hour_d;
    logic [7:0]    day_d;
    logic [7:0]    mon_d;
    logic [7:0]    year_d;
    logic          c_min;
    logic          c_hour;
    logic          c_day;
    logic          c_mon;
    logic          c_year;

    // Next value of one time field: wrap at max, otherwise a per-nibble BCD step.
    // Non-BCD contents take the same step with no correction.
    function automatic logic [7:0] bcd_next(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v == hi)
            bcd_next = lo;
        else if (v[3:0] == 4'd9)
            bcd_next = {v[7:4] + 4'd1, 4'd0};
        else
            bcd_next = {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Bus pins are only ever looked at through these registered copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_a_d <= 1'b1;
            prev_cs  <= 1'b1;
            prev_rd  <= 1'b1;
            prev_wr  <= 1'b1;
            prev_bus <= 8'h00;
        end else begin
            prev_a_d <= a_d;
            prev_cs  <= cs;
            prev_rd  <= rd;
            prev_wr  <= wr;
            prev_bus <= add_data_rtc;
        end
    end

    // bus_hold keeps the last bus value seen while the write strobe was low, so the
    // address/data committed when wr rises is the one the host presented, not the
    // value floating on the bus after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus_hold <= 8'h00;
        else if (!prev_cs && !prev_wr)
            bus_hold <= prev_bus;
    end

    // Host protocol: an access opens with cs, wr and a_d all low (address phase) and
    // closes it by raising cs or wr; the data phase is cs low with a_d high and exactly
    // one of rd/wr low, and the rising strobe (or cs) ends it. rd and wr low together
    // are ignored.
    always_comb begin
        next_state = state;
        load_addr  = 1'b0;
        load_rbuf  = 1'b0;
        commit_wr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!prev_cs && !prev_wr && !prev_a_d)
                    next_state = S_ADDR;
            end
            S_ADDR: begin
                if (prev_cs || prev_wr) begin
                    next_state = S_WAIT;
                    load_addr  = 1'b1;
                end
            end
            S_WAIT: begin
                if (!prev_cs && prev_a_d && !prev_rd && prev_wr) begin
                    next_state = S_READ;
                    load_rbuf  = 1'b1;
                end else if (!prev_cs && prev_a_d && !prev_wr && prev_rd) begin
                    next_state = S_WRITE;
                end else if (!prev_cs && !prev_a_d && !prev_wr && prev_rd) begin
                    next_state = S_ADDR;
                end
            end
            S_READ: begin
                if (prev_rd || prev_cs)
                    next_state = S_IDLE;
            end
            S_WRITE: begin
                if (prev_wr || prev_cs) begin
                    next_state = S_IDLE;
                    commit_wr  = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            oe    <= 1'b0;
        end else begin
            state <= next_state;
            oe    <= (next_state == S_READ);
        end
    end

    always_comb begin
        case (addr)
            8'h21:   rd_mux = rtc_sec;
            8'h22:   rd_mux = rtc_min;
            8'h23:   rd_mux = rtc_hour;
            8'h24:   rd_mux = rtc_day;
            8'h25:   rd_mux = rtc_mon;
            8'h26:   rd_mux = rtc_year;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= 8'h00;
            rbuf <= 8'h00;
        end else begin
            if (load_addr)
                addr <= bus_hold;
            if (load_rbuf)
                rbuf <= rd_mux;
        end
    end

    // The read buffer is a snapshot, so a tick during a read cannot disturb the bus.
    assign add_data_rtc = oe ? rbuf : 8'hzz;

    assign tick   = (presc == PRESC_LAST);
    assign c_min  = tick   && (rtc_sec  == 8'h59);
    assign c_hour = c_min  && (rtc_min  == 8'h59);
    assign c_day  = c_hour && (rtc_hour == 8'h23);
    assign c_mon  = c_day  && (rtc_day  == 8'h31);
    assign c_year = c_mon  && (rtc_mon  == 8'h12);

    // Tick/carry result for every field first; a committing bus write then
    // overrides only the field it addresses.
    always_comb begin
        sec_d  = tick   ? bcd_next(rtc_sec,  8'h00, 8'h59) : rtc_sec;
        min_d  = c_min  ? bcd_next(rtc_min,  8'h00, 8'h59) : rtc_min;
        hour_d = c_hour ? bcd_next(rtc_hour, 8'h00, 8'h23) : rtc_hour;
        day_d  = c_day  ? bcd_next(rtc_day,  8'h01, 8'h31) : rtc_day;
        mon_d  = c_mon  ? bcd_next(rtc_mon,  8'h01, 8'h12) : rtc_mon;
        year_d = c_year ? bcd_next(rtc_year, 8'h00, 8'h99) : rtc_year;
        if (commit_wr) begin
            case (addr)
                8'h21:   sec_d  = bus_hold;
                8'h22:   min_d  = bus_hold;
                8'h23:   hour_d = bus_hold;
                8'h24:   day_d  = bus_hold;
                8'h25:   mon_d  = bus_hold;
                8'h26:   year_d = bus_hold;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtc_sec  <= 8'h00;
            rtc_min  <= 8'h00;
            rtc_hour <= 8'h00;
            rtc_day  <= 8'h01;
            rtc_mon  <= 8'h01;
            rtc_year <= 8'h00;
        end else begin
            rtc_sec  <= sec_d;
            rtc_min  <= min_d;
            rtc_hour <= hour_d;
            rtc_day  <= day_d;
            rtc_mon  <= mon_d;
            rtc_year <= year_d;
        end
    end

    // Writing seconds restarts the current second from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc         <= '0;
            segundo_pulso <= 1'b0;
        end else begin
            segundo_pulso <= tick;
            if ((commit_wr && (addr == 8'h21)) || tick)
                presc <= '0;
            else
                presc <= presc + PW'(1);
        end
    end

endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000: clk cycles per timekeeping second; benches use 10.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_d  input  1  address/data select, active low: 0 = address phase, 1 = data phase.
REQ-005 cs  input  1  chip select, active low.
REQ-006 rd  input  1  read strobe, active low.
REQ-007 wr  input  1  write strobe, active low.
REQ-008 add_data_rtc  inout  8  multiplexed address/data bus; driven only while oe=1, otherwise 8'hzz.
REQ-009 segundo_pulso  output  1  one-cycle pulse on each timekeeping second.

Function
REQ-010 The block SHALL register a_d, cs, rd, wr and the bus value every cycle (prev_*). All edge detection and latching SHALL use these registered copies.
REQ-011 The block SHALL implement these register addresses, all BCD:
- 0x21 seconds, 00-59
- 0x22 minutes, 00-59
- 0x23 hours, 00-23
- 0x24 day, 01-31
- 0x25 month, 01-12
- 0x26 year, 00-99
REQ-012 Reads of any unmapped address SHALL return 0x00. Writes to any unmapped address SHALL be ignored.
REQ-013 Bus FSM states SHALL be IDLE, ADDR, WAIT, READ, WRITE.
REQ-014 IDLE -> ADDR when sampled cs=0, wr=0, a_d=0.
REQ-015 ADDR -> WAIT when cs=1 or wr=1. On that transition the address register SHALL load prev bus, i.e. the value sampled while wr was still low.
REQ-016 WAIT:
- cs=0, rd=0, a_d=1 -> READ; the addressed register value SHALL be captured into a read buffer.
- cs=0, wr=0, a_d=1 -> WRITE.
- cs=0, wr=0, a_d=0 -> ADDR.
- Otherwise remain in WAIT.
REQ-017 READ: oe=1 and the bus is driven with the read buffer, starting the cycle after READ is entered. When rd=1 or cs=1: oe=0 the next cycle, go to IDLE.
REQ-018 WRITE: oe stays 0. When wr=1 or cs=1: store prev bus into the addressed register, go to IDLE.
REQ-019 rd=0 and wr=0 sampled together in WAIT SHALL be treated as neither: remain in WAIT, bus never driven.
REQ-020 Written values SHALL be stored verbatim, including non-BCD values.
REQ-021 The prescaler SHALL count 0..TICKS_PER_SEC-1 and then wrap. On wrap it SHALL raise segundo_pulso for one cycle and increment seconds.
REQ-022 Increment rule per field:
- If field == max: load min and carry to the next field.
- Else if low nibble == 9: low nibble = 0, high nibble + 1.
- Else: low nibble + 1.
REQ-023 Carry chain: seconds -> minutes -> hours -> day -> month -> year. Year 99 wraps to 00 with no further carry. Every month is 31 days.
REQ-024 A non-BCD stored value SHALL increment by the same rule, with no saturation or correction.
REQ-025 A bus write and a tick in the same cycle: the write SHALL win for the written field. All other fields SHALL take the tick/carry result.
REQ-026 A write to 0x21 SHALL clear the prescaler to 0.
REQ-027 Read data SHALL be the read-buffer snapshot. A tick during READ SHALL NOT change the driven value.
REQ-028 oe SHALL be 0 in every state except READ.

Reset
REQ-029 On reset, asynchronously and with effect during any bus phase:
- FSM = IDLE
- oe = 0 (bus 8'hzz)
- address = 0x00, read buffer = 0x00
- prescaler = 0, segundo_pulso = 0
- seconds 00, minutes 00, hours 00, day 01, month 01, year 00

Verification (TICKS_PER_SEC=10)
REQ-030 Write then read back:
- Address 0x23, then write data 0x17 (a_d high, wr low 3 cycles).
- Then address 0x23, then read (rd low 3 cycles).
- Required: bus = 0x17 from the second rd-low cycle; 8'hzz one cycle after rd rises.
REQ-031 Rollover: write 23:59:59, day 31, month 12, year 99; wait 10 cycles. Required: segundo_pulso for one cycle; all fields read 00:00:00, day 01, month 01, year 00.
REQ-032 Write/tick collision: write minutes 0x45 in the same cycle seconds carries from 59. Required: minutes = 0x45, seconds = 00.
REQ-033 Unmapped address: write 0x99 to 0x30, then read 0x30. Required: read returns 0x00; registers 0x21-0x26 unchanged.
REQ-034 Reset mid-read: assert reset while rd=0 and oe=1. Required: bus 8'hzz immediately; a subsequent read of 0x24 returns 0x01.
REQ-035 Verify no contention: bus is 8'hzz throughout every address phase and every write phase.
